mul_div_unit: RTL and testbench

Multi-cycle signed multiply/divide unit for the 32-bit datapath. It sits directly downstream of the bus: operand A comes from the Y register, operand B comes from the bus output, both sampled on a start pulse. The 64-bit result is held in Z high/Z low registers, which drive the ZHI/ZLO bus inputs back onto the bus. Multiply uses radix-4 bit-pair Booth recoding; divide uses non-restoring division.

---
 rtl/mdu_pkg.sv | 23 ++
 rtl/mul_div_unit_booth_pair_recoder.sv | 20 ++
 rtl/mul_div_unit.sv | 175 +++++++++++++++++
 tb/tb_mul_div_unit.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared types and constants for the multi-cycle multiply/divide unit.
package mdu_pkg;

    localparam int MUL_ITERS = 16;
    localparam int DIV_ITERS = 32;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        DIV,
        FIX,
        DONE
    } state_e;

    typedef enum logic [2:0] {
        ZERO,
        PLUS1,
        PLUS2,
        MINUS1,
        MINUS2
    } booth_sel_e;

endpackage

// File: rtl/mul_div_unit_booth_pair_recoder.sv
// Radix-4 Booth recoder: maps a 3-bit multiplier window to a multiple of A.
module booth_pair_recoder
    import mdu_pkg::*;
(
    input  logic [2:0] window,
    output logic [2:0] sel
);

    always_comb begin
        sel = ZERO;
        case (window)
            3'b001, 3'b010: sel = PLUS1;
            3'b011:         sel = PLUS2;
            3'b100:         sel = MINUS2;
            3'b101, 3'b110: sel = MINUS1;
            default:        sel = ZERO;
        endcase
    end

endmodule

// File: rtl/mul_div_unit.sv
// Signed multiply (radix-4 Booth) / divide (non-restoring) unit feeding ZHI/ZLO.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic             op_div,
    input  logic [WIDTH-1:0] bus_in,
    input  logic [WIDTH-1:0] y_in,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] z_high,
    output logic [WIDTH-1:0] z_low
);

    localparam int AW = WIDTH + 2;

    state_e           state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, lo_q, lo_d;
    logic [WIDTH-1:0] zh_q, zh_d, zl_q, zl_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic             bneg_q, bneg_d, mprev_q, mprev_d, dbz_q, dbz_d;

    logic [2:0]       sel;
    logic [AW-1:0]    a_ext, add_x, add_y, sum;
    logic             add_sub;
    logic [WIDTH-1:0] a_mag, b_mag, r_mag, q_fix, r_fix;

    booth_pair_recoder u_rec (
        .window ({lo_q[1:0], mprev_q}),
        .sel    (sel)
    );

    assign a_ext = {{2{a_q[WIDTH-1]}}, a_q};
    assign a_mag = y_in[WIDTH-1] ? (~y_in + WIDTH'(1)) : y_in;
    assign b_mag = bus_in[WIDTH-1] ? (~bus_in + WIDTH'(1)) : bus_in;

    // The one adder/subtractor shared by the MUL, DIV and FIX steps.
    always_comb begin
        add_x   = acc_q;
        add_y   = '0;
        add_sub = 1'b0;
        case (state_q)
            MUL: begin
                case (sel)
                    PLUS1:  add_y = a_ext;
                    PLUS2:  add_y = {a_ext[AW-2:0], 1'b0};
                    MINUS1: begin add_y = a_ext; add_sub = 1'b1; end
                    MINUS2: begin add_y = {a_ext[AW-2:0], 1'b0}; add_sub = 1'b1; end
                    default: add_y = '0;
                endcase
            end
            DIV: begin
                add_x   = {acc_q[AW-2:0], lo_q[WIDTH-1]};
                add_y   = {2'b00, b_q};
                add_sub = ~acc_q[AW-1];
            end
            FIX: add_y = {2'b00, b_q};
            default: ;
        endcase
    end

    assign sum   = add_x + (add_sub ? ~add_y : add_y) + AW'(add_sub);
    assign r_mag = acc_q[AW-1] ? sum[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign q_fix = (a_q[WIDTH-1] ^ bneg_q) ? (~lo_q + WIDTH'(1)) : lo_q;
    assign r_fix = a_q[WIDTH-1] ? (~r_mag + WIDTH'(1)) : r_mag;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        lo_d    = lo_q;
        acc_d   = acc_q;
        bneg_d  = bneg_q;
        mprev_d = mprev_q;
        dbz_d   = dbz_q;
        zh_d    = zh_q;
        zl_d    = zl_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = y_in;
                    b_d     = b_mag;
                    bneg_d  = bus_in[WIDTH-1];
                    cnt_d   = '0;
                    acc_d   = '0;
                    mprev_d = 1'b0;
                    dbz_d   = 1'b0;
                    if (!op_div) begin
                        lo_d    = bus_in;
                        state_d = MUL;
                    end else begin
                        lo_d = a_mag;
                        // Zero divisor skips the loop; FIX posts the flagged result.
                        state_d = (bus_in == '0) ? FIX : DIV;
                    end
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            MUL: begin
                acc_d   = {{2{sum[AW-1]}}, sum[AW-1:2]};
                lo_d    = {sum[1:0], lo_q[WIDTH-1:2]};
                mprev_d = lo_q[1];
                cnt_d   = cnt_q + 5'd1;
                if (cnt_q == 5'(MUL_ITERS - 1)) begin
                    zh_d    = sum[WIDTH+1:2];
                    zl_d    = {sum[1:0], lo_q[WIDTH-1:2]};
                    state_d = DONE;
                end
            end
            DIV: begin
                acc_d = sum;
                lo_d  = {lo_q[WIDTH-2:0], ~sum[AW-1]};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'(DIV_ITERS - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = DONE;
                if (b_q == '0) begin
                    zl_d  = '1;
                    zh_d  = a_q;
                    dbz_d = 1'b1;
                end else begin
                    zl_d = q_fix;
                    zh_d = r_fix;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            lo_q    <= '0;
            acc_q   <= '0;
            bneg_q  <= 1'b0;
            mprev_q <= 1'b0;
            dbz_q   <= 1'b0;
            zh_q    <= '0;
            zl_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            lo_q    <= lo_d;
            acc_q   <= acc_d;
            bneg_q  <= bneg_d;
            mprev_q <= mprev_d;
            dbz_q   <= dbz_d;
            zh_q    <= zh_d;
            zl_q    <= zl_d;
        end
    end

    assign busy        = (state_q == MUL) || (state_q == DIV) || (state_q == FIX);
    assign done        = (state_q == DONE);
    assign div_by_zero = dbz_q;
    assign z_high      = zh_q;
    assign z_low       = zl_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Table-driven and scoreboard checks for mul_div_unit.
module tb_mul_div_unit;

    logic        clock = 1'b0;
    logic        clear, start, op_div;
    logic [31:0] bus_in, y_in, z_high, z_low;
    logic        busy, done, div_by_zero;

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          lat;
    } exp_t;

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          lat;
    } vec_t;

    exp_t sb[$];

    mul_div_unit #(.WIDTH(32)) dut (
        .clock       (clock),
        .clear       (clear),
        .start       (start),
        .op_div      (op_div),
        .bus_in      (bus_in),
        .y_in        (y_in),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .z_high      (z_high),
        .z_low       (z_low)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic exp_t model(input logic op, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint p;
        int     q, r;
        e.dbz = 1'b0;
        if (!op) begin
            p    = longint'($signed(a)) * longint'($signed(b));
            e.hi = p[63:32];
            e.lo = p[31:0];
            e.lat = 16;
        end else if (b == 32'h0) begin
            e.hi  = a;
            e.lo  = 32'hFFFFFFFF;
            e.dbz = 1'b1;
            e.lat = 1;
        end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
            e.hi  = 32'h0;
            e.lo  = 32'h80000000;
            e.lat = 33;
        end else begin
            q     = $signed(a) / $signed(b);
            r     = $signed(a) % $signed(b);
            e.hi  = r;
            e.lo  = q;
            e.lat = 33;
        end
        return e;
    endfunction

    // Drive start in the current cycle; returns 1 ns after the accepting edge.
    task automatic launch(input logic op, input logic [31:0] a, input logic [31:0] b,
                          input exp_t e);
        start  = 1'b1;
        op_div = op;
        y_in   = a;
        bus_in = b;
        sb.push_back(e);
        @(posedge clock);
        #1;
        start  = 1'b0;
        op_div = 1'($urandom);
        y_in   = $urandom;
        bus_in = $urandom;
    endtask

    task automatic wait_done(input int poke);
        int   n  = 0;
        int   nb = 0;
        exp_t e;
        if (busy) nb++;
        while (!done && n < 200) begin
            if (n == poke) begin
                start  = 1'b1;
                op_div = 1'b0;
                y_in   = 32'h5;
                bus_in = 32'h5;
            end
            @(posedge clock);
            #1;
            start = 1'b0;
            n++;
            if (busy) nb++;
        end
        if (sb.size() == 0) begin
            checks++;
            $display("FAIL scoreboard: got empty queue expected an entry");
        end else begin
            e = sb.pop_front();
            chk("latency", 64'(n), 64'(e.lat));
            chk("busy_cycles", 64'(nb), 64'(e.lat));
            chk("result", {z_high, z_low}, {e.hi, e.lo});
            chk("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
        end
    endtask

    vec_t vecs[11];
    exp_t ex;

    initial begin
        vecs[0]  = '{1'b0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 16};
        vecs[1]  = '{1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 16};
        vecs[2]  = '{1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0, 16};
        vecs[3]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 16};
        vecs[4]  = '{1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33};
        vecs[5]  = '{1'b1, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 33};
        vecs[6]  = '{1'b1, 32'h12345678, 32'h0,        32'h12345678, 32'hFFFFFFFF, 1'b1, 1};
        vecs[7]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33};
        vecs[8]  = '{1'b1, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, 33};
        vecs[9]  = '{1'b1, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'd2,        1'b0, 33};
        vecs[10] = '{1'b0, 32'd0,        32'h12345678, 32'd0,        32'd0,        1'b0, 16};

        clear  = 1'b0;
        start  = 1'b0;
        op_div = 1'b0;
        bus_in = '0;
        y_in   = '0;
        #12;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_dbz", 64'(div_by_zero), 64'd0);
        chk("reset_z", {z_high, z_low}, 64'd0);
        @(negedge clock);
        clear = 1'b1;
        @(negedge clock);

        foreach (vecs[i]) begin
            ex.hi  = vecs[i].hi;
            ex.lo  = vecs[i].lo;
            ex.dbz = vecs[i].dbz;
            ex.lat = vecs[i].lat;
            launch(vecs[i].op, vecs[i].a, vecs[i].b, ex);
            chk("busy_after_start", 64'(busy), 64'd1);
            wait_done(-1);
            @(posedge clock);
            #1;
            chk("done_one_cycle", 64'(done), 64'd0);
            chk("z_hold", {z_high, z_low}, {vecs[i].hi, vecs[i].lo});
            @(negedge clock);
        end

        for (int k = 0; k < 8; k++) begin
            logic        op;
            logic [31:0] a, b;
            op = 1'($urandom);
            a  = $urandom;
            b  = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
            launch(op, a, b, model(op, a, b));
            wait_done(-1);
            @(negedge clock);
        end

        // Start pulsed mid-divide must be ignored.
        launch(1'b1, 32'd100, 32'd7, model(1'b1, 32'd100, 32'd7));
        wait_done(10);
        @(negedge clock);

        // Back-to-back: multiply accepted in the divide's DONE cycle.
        launch(1'b1, 32'hFFFFFFF9, 32'd2, model(1'b1, 32'hFFFFFFF9, 32'd2));
        wait_done(-1);
        launch(1'b0, 32'd7, 32'hFFFFFFFD, model(1'b0, 32'd7, 32'hFFFFFFFD));
        chk("b2b_div_held", {z_high, z_low}, {32'hFFFFFFFF, 32'hFFFFFFFD});
        chk("b2b_busy", 64'(busy), 64'd1);
        wait_done(-1);
        @(negedge clock);

        // Clear during iteration 10 of a multiply.
        start  = 1'b1;
        op_div = 1'b0;
        y_in   = 32'd1234;
        bus_in = 32'd5678;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clock);
        @(negedge clock);
        clear = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_z", {z_high, z_low}, 64'd0);
        chk("abort_dbz", 64'(div_by_zero), 64'd0);
        @(negedge clock);
        clear = 1'b1;
        #1;
        launch(1'b0, 32'd3, 32'd4, model(1'b0, 32'd3, 32'd4));
        chk("post_clear_busy", 64'(busy), 64'd1);
        wait_done(-1);
        chk("post_clear_lo", 64'(z_low), 64'd12);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
